// File: rtl/ex_sched_pkg.sv
// Shared types and constants for the Execute-stage multiplier/divider scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ex_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam logic [2:0] MULSEL_NONE = 3'd0;
    localparam logic [2:0] MUL         = 3'd1;
    localparam logic [2:0] MULH        = 3'd2;
    localparam logic [2:0] MULHSU      = 3'd3;
    localparam logic [2:0] MULHU       = 3'd4;
    localparam logic [2:0] DIV         = 3'd5;
    localparam logic [2:0] REM         = 3'd6;

    localparam int DEF_TIMEOUT_CYC = 40;

endpackage

// File: rtl/ex_sched_timer.sv
// Clearable up-counter with a terminal-count flag for the unit timeout.
// Latency: tc is combinational from the registered count.
// Backpressure: none; clr has priority over en.
module ex_sched_timer #(
    parameter int CNT_W = 8,
    parameter int TERM  = 39
) (
    input  logic clk,
    input  logic Rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == TERM_C);

endmodule

// File: rtl/ex_mul_sched.sv
// Issue/stall controller for the multi-cycle mul/div unit; EX_MUL_SCHED_PERF_EN adds perf counters.
// Latency: request cycle 0 -> unit_start cycle 1 -> res_valid one cycle after unit_done.
// Backpressure: ex_stall holds the front end while busy; freeze holds IDLE issue and the DONE result.
module ex_mul_sched
    import ex_sched_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [4:0]  req_rd,
    output logic        unit_start,
    output logic [2:0]  unit_op,
    output logic        unit_abort,
    input  logic        unit_done,
    input  logic [31:0] unit_res,
    output logic        ex_stall,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [4:0]  res_rd,
    output logic        busy,
    output logic        err
`ifdef EX_MUL_SCHED_PERF_EN
    ,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_stall
`endif
);

    sched_state_t state, state_nxt;
    logic live;
    logic issue;
    logic capture;
    logic abort_nxt;
    logic err_nxt;
    logic timeout;

    assign live = req_valid && (req_op != MULSEL_NONE);

    ex_sched_timer #(
        .CNT_W (CNT_W),
        .TERM  (TIMEOUT_CYC - 1)
    ) u_timer (
        .clk (clk),
        .Rst (Rst),
        .clr (state == ISSUE),
        .en  (state == WAIT),
        .tc  (timeout)
    );

    always_comb begin
        state_nxt = state;
        ex_stall  = 1'b0;
        issue     = 1'b0;
        capture   = 1'b0;
        abort_nxt = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                ex_stall = live && !flush;
                if (live && !flush && !freeze) begin
                    issue     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                ex_stall = 1'b1;
                if (flush) begin
                    abort_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                ex_stall = 1'b1;
                // flush beats a same-cycle result; a same-cycle result beats the timeout
                if (flush) begin
                    abort_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (unit_done) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else if (timeout) begin
                    err_nxt   = 1'b1;
                    abort_nxt = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (flush || !freeze) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            unit_start <= 1'b0;
            unit_abort <= 1'b0;
            err        <= 1'b0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
            unit_op    <= '0;
            res_rd     <= '0;
            res_data   <= '0;
        end else begin
            state      <= state_nxt;
            unit_start <= issue;
            unit_abort <= abort_nxt;
            err        <= err_nxt;
            res_valid  <= (state_nxt == DONE);
            busy       <= (state_nxt != IDLE);
            if (issue) begin
                unit_op <= req_op;
                res_rd  <= req_rd;
            end
            if (capture) begin
                res_data <= unit_res;
            end else if (err_nxt) begin
                res_data <= '0;
            end
        end
    end

`ifdef EX_MUL_SCHED_PERF_EN
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (capture && (perf_ops != 32'hFFFF_FFFF)) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if (ex_stall && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_mul_sched.sv
// Self-checking bench for ex_mul_sched: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a timestamp-based operation model.
module tb_ex_mul_sched;

    localparam int TB_TO = 4;

    logic        clk;
    logic        Rst;
    logic        freeze;
    logic        flush;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [4:0]  req_rd;
    logic        unit_start;
    logic [2:0]  unit_op;
    logic        unit_abort;
    logic        unit_done;
    logic [31:0] unit_res;
    logic        ex_stall;
    logic        res_valid;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        busy;
    logic        err;
`ifdef EX_MUL_SCHED_PERF_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    ex_mul_sched #(
        .TIMEOUT_CYC (TB_TO),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .Rst        (Rst),
        .freeze     (freeze),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_rd     (req_rd),
        .unit_start (unit_start),
        .unit_op    (unit_op),
        .unit_abort (unit_abort),
        .unit_done  (unit_done),
        .unit_res   (unit_res),
        .ex_stall   (ex_stall),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_rd     (res_rd),
        .busy       (busy),
        .err        (err)
`ifdef EX_MUL_SCHED_PERF_EN
        ,
        .perf_ops   (perf_ops),
        .perf_stall (perf_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Operation model: one op in flight, tracked by the cycle number of its start pulse.
    int          ncyc = 0;
    bit          op_on;
    bit          presenting;
    int          start_cyc;
    int          abort_cyc;
    int          err_cyc;
    logic [2:0]  m_op;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    always @(negedge clk) begin : model
        logic lv;
        lv = req_valid && (req_op != 3'd0);
        if (Rst) begin
            op_on      = 1'b0;
            presenting = 1'b0;
            start_cyc  = -10;
            abort_cyc  = -10;
            err_cyc    = -10;
            m_op       = '0;
            m_rd       = '0;
            m_data     = '0;
        end else begin
            chk("m_busy",      {31'd0, busy},       {31'd0, op_on});
            chk("m_res_valid", {31'd0, res_valid},  {31'd0, presenting});
            chk("m_start",     {31'd0, unit_start}, {31'd0, ncyc == start_cyc});
            chk("m_abort",     {31'd0, unit_abort}, {31'd0, ncyc == abort_cyc});
            chk("m_err",       {31'd0, err},        {31'd0, ncyc == err_cyc});
            chk("m_stall",     {31'd0, ex_stall},
                {31'd0, op_on ? !presenting : (lv && !flush)});
            chk("m_unit_op",   {29'd0, unit_op},    {29'd0, m_op});
            chk("m_res_rd",    {27'd0, res_rd},     {27'd0, m_rd});
            chk("m_res_data",  res_data,            m_data);

            if (!op_on) begin
                if (lv && !flush && !freeze) begin
                    op_on     = 1'b1;
                    start_cyc = ncyc + 1;
                    m_op      = req_op;
                    m_rd      = req_rd;
                end
            end else if (presenting) begin
                if (flush || !freeze) begin
                    op_on      = 1'b0;
                    presenting = 1'b0;
                end
            end else if (flush) begin
                op_on     = 1'b0;
                abort_cyc = ncyc + 1;
            end else if (ncyc > start_cyc) begin
                if (unit_done) begin
                    m_data     = unit_res;
                    presenting = 1'b1;
                end else if (ncyc - start_cyc == TB_TO) begin
                    m_data     = '0;
                    presenting = 1'b1;
                    err_cyc    = ncyc + 1;
                    abort_cyc  = ncyc + 1;
                end
            end
        end
        ncyc++;
    end

    task automatic cyc_set(input logic v, input logic [2:0] op, input logic [4:0] rd,
                           input logic fz, input logic fl, input logic dn,
                           input logic [31:0] res);
        @(posedge clk);
        #1;
        req_valid = v;
        req_op    = op;
        req_rd    = rd;
        freeze    = fz;
        flush     = fl;
        unit_done = dn;
        unit_res  = res;
        @(negedge clk);
    endtask

    int cd;

    initial begin
        Rst       = 1'b1;
        freeze    = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_rd    = '0;
        unit_done = 1'b0;
        unit_res  = '0;
        cd        = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  {31'd0, busy},       32'd0);
        chk("rst_start", {31'd0, unit_start}, 32'd0);
        chk("rst_rv",    {31'd0, res_valid},  32'd0);
        chk("rst_err",   {31'd0, err},        32'd0);
        chk("rst_abort", {31'd0, unit_abort}, 32'd0);
        chk("rst_data",  res_data,            32'd0);
        Rst = 1'b0;

        // Basic: done in 2nd WAIT cycle
        cyc_set(1, 3'd1, 5'd5, 0, 0, 0, 0);
        chk("b0_stall", {31'd0, ex_stall},   32'd1);
        chk("b0_busy",  {31'd0, busy},       32'd0);
        cyc_set(1, 3'd1, 5'd5, 0, 0, 0, 0);
        chk("b1_start", {31'd0, unit_start}, 32'd1);
        chk("b1_op",    {29'd0, unit_op},    32'd1);
        cyc_set(1, 3'd1, 5'd5, 0, 0, 0, 0);
        chk("b2_start", {31'd0, unit_start}, 32'd0);
        chk("b2_stall", {31'd0, ex_stall},   32'd1);
        cyc_set(1, 3'd1, 5'd5, 0, 0, 1, 32'h0000_00C8);
        chk("b3_stall", {31'd0, ex_stall},   32'd1);
        cyc_set(1, 3'd1, 5'd5, 0, 0, 0, 0);
        chk("b4_rv",    {31'd0, res_valid},  32'd1);
        chk("b4_data",  res_data,            32'h0000_00C8);
        chk("b4_rd",    {27'd0, res_rd},     32'd5);
        chk("b4_stall", {31'd0, ex_stall},   32'd0);
        cyc_set(0, 3'd0, 5'd0, 0, 0, 0, 0);
        chk("b5_busy",  {31'd0, busy},       32'd0);
        chk("b5_rv",    {31'd0, res_valid},  32'd0);

        // Freeze held for three DONE cycles; stray done pulses must be ignored
        cyc_set(1, 3'd1, 5'd5, 0, 0, 0, 0);
        cyc_set(1, 3'd1, 5'd5, 0, 0, 0, 0);
        cyc_set(1, 3'd1, 5'd5, 0, 0, 0, 0);
        cyc_set(1, 3'd1, 5'd5, 0, 0, 1, 32'h1234_5678);
        for (int k = 0; k < 3; k++) begin
            cyc_set(1, 3'd1, 5'd5, 1, 0, 1, 32'h0000_AAAA);
            chk("fz_rv",    {31'd0, res_valid},  32'd1);
            chk("fz_data",  res_data,            32'h1234_5678);
            chk("fz_start", {31'd0, unit_start}, 32'd0);
        end
        cyc_set(1, 3'd1, 5'd5, 0, 0, 0, 0);
        chk("fz_rv_last", {31'd0, res_valid}, 32'd1);
        cyc_set(0, 3'd0, 5'd0, 0, 0, 0, 0);
        chk("fz_busy",  {31'd0, busy},       32'd0);
        chk("fz_start2", {31'd0, unit_start}, 32'd0);

        // Timeout after TB_TO WAIT cycles
        cyc_set(1, 3'd5, 5'd9, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc_set(1, 3'd5, 5'd9, 0, 0, 0, 0);
        chk("to_err_early", {31'd0, err}, 32'd0);
        cyc_set(1, 3'd5, 5'd9, 0, 0, 0, 0);
        chk("to_err",   {31'd0, err},        32'd1);
        chk("to_abort", {31'd0, unit_abort}, 32'd1);
        chk("to_rv",    {31'd0, res_valid},  32'd1);
        chk("to_data",  res_data,            32'd0);
        chk("to_rd",    {27'd0, res_rd},     32'd9);
        cyc_set(0, 3'd0, 5'd0, 0, 0, 1, 32'h0000_FFFF);
        chk("to_err_after", {31'd0, err},       32'd0);
        chk("to_rv_after",  {31'd0, res_valid}, 32'd0);
        cyc_set(0, 3'd0, 5'd0, 0, 0, 0, 0);
        chk("to_data_after", res_data, 32'd0);

        // Flush beats a same-cycle done in WAIT
        cyc_set(1, 3'd2, 5'd3, 0, 0, 0, 0);
        cyc_set(1, 3'd2, 5'd3, 0, 0, 0, 0);
        cyc_set(1, 3'd2, 5'd3, 0, 1, 1, 32'hDEAD_BEEF);
        cyc_set(0, 3'd0, 5'd0, 0, 0, 0, 0);
        chk("fl_abort", {31'd0, unit_abort}, 32'd1);
        chk("fl_busy",  {31'd0, busy},       32'd0);
        chk("fl_rv",    {31'd0, res_valid},  32'd0);
        chk("fl_data",  res_data,            32'd0);
        cyc_set(0, 3'd0, 5'd0, 0, 0, 0, 0);
        chk("fl_abort2", {31'd0, unit_abort}, 32'd0);
        chk("fl_rv2",    {31'd0, res_valid},  32'd0);

        // Asynchronous reset mid-WAIT
        cyc_set(1, 3'd6, 5'd7, 0, 0, 0, 0);
        cyc_set(1, 3'd6, 5'd7, 0, 0, 0, 0);
        cyc_set(1, 3'd6, 5'd7, 0, 0, 0, 0);
        #2;
        Rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        #1;
        chk("ar_busy",  {31'd0, busy},       32'd0);
        chk("ar_op",    {29'd0, unit_op},    32'd0);
        chk("ar_rd",    {27'd0, res_rd},     32'd0);
        chk("ar_abort", {31'd0, unit_abort}, 32'd0);
        chk("ar_stall", {31'd0, ex_stall},   32'd0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        Rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc_set(0, 3'd0, 5'd0, 0, 0, 0, 0);
            chk("ar_no_abort", {31'd0, unit_abort}, 32'd0);
        end

        // Back-to-back ops, then an ignored req_op=0
        cyc_set(1, 3'd5, 5'd1, 0, 0, 0, 0);
        cyc_set(1, 3'd5, 5'd1, 0, 0, 0, 0);
        chk("bb_start1", {31'd0, unit_start}, 32'd1);
        cyc_set(1, 3'd5, 5'd1, 0, 0, 1, 32'h0000_0011);
        cyc_set(1, 3'd5, 5'd1, 0, 0, 0, 0);
        chk("bb_done_start", {31'd0, unit_start}, 32'd0);
        chk("bb_done_stall", {31'd0, ex_stall},   32'd0);
        chk("bb_done_data",  res_data,            32'h0000_0011);
        cyc_set(1, 3'd1, 5'd2, 0, 0, 0, 0);
        chk("bb_idle_start", {31'd0, unit_start}, 32'd0);
        chk("bb_idle_stall", {31'd0, ex_stall},   32'd1);
        cyc_set(1, 3'd1, 5'd2, 0, 0, 0, 0);
        chk("bb_start2", {31'd0, unit_start}, 32'd1);
        chk("bb_op2",    {29'd0, unit_op},    32'd1);
        cyc_set(1, 3'd1, 5'd2, 0, 0, 1, 32'h0000_0022);
        cyc_set(1, 3'd1, 5'd2, 0, 0, 0, 0);
        chk("bb_rv2",   {31'd0, res_valid}, 32'd1);
        chk("bb_data2", res_data,           32'h0000_0022);
        chk("bb_rd2",   {27'd0, res_rd},    32'd2);
        cyc_set(1, 3'd0, 5'd4, 0, 0, 0, 0);
        chk("nop_stall", {31'd0, ex_stall}, 32'd0);
        cyc_set(1, 3'd0, 5'd4, 0, 0, 0, 0);
        chk("nop_start", {31'd0, unit_start}, 32'd0);
        chk("nop_busy",  {31'd0, busy},       32'd0);

        // Randomized traffic with a responder standing in for the unit
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            unit_done = 1'b0;
            if (unit_abort) cd = 0;
            if (unit_start) begin
                cd = $urandom_range(1, TB_TO + 1);
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    unit_done = 1'b1;
                    unit_res  = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                unit_done = 1'b1;
                unit_res  = $urandom;
            end
            req_valid = ($urandom_range(0, 3) != 0);
            req_op    = 3'($urandom_range(0, 7));
            req_rd    = 5'($urandom_range(0, 31));
            freeze    = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 11) == 0);
        end

        @(posedge clk);
        #1;
        req_valid = 1'b0;
        freeze    = 1'b0;
        flush     = 1'b0;
        unit_done = 1'b0;
        repeat (TB_TO + 4) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
